// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared types and constants for the APB master bridge.
// Holds the bridge FSM state encoding and the register map of the I2C subsystem completer.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam logic [31:0] ADDR_TX_FIFO = 32'h0;
    localparam logic [31:0] ADDR_RX_FIFO = 32'h4;
    localparam logic [31:0] ADDR_CONFIG  = 32'h8;
    localparam logic [31:0] ADDR_TIMEOUT = 32'hC;

endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command, response and APB bus signals of the APB master bridge.
// Modports:
//   master - the bridge: it consumes commands, produces responses and drives the APB requester side.
//   slave  - the environment: the command source, the response sink and the APB completer.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              CMD_VALID;
    logic              CMD_READY;
    logic              CMD_WRITE;
    logic [ADDR_W-1:0] CMD_ADDR;
    logic [DATA_W-1:0] CMD_WDATA;
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [DATA_W-1:0] RSP_RDATA;
    logic              RSP_SLVERR;
    logic              RSP_TIMEOUT;
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, PRDATA, PREADY, PSLVERR,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_SLVERR, RSP_TIMEOUT,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, PRDATA, PREADY, PSLVERR,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_SLVERR, RSP_TIMEOUT,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_master_wdog.sv
// apb_master_wdog: counts ACCESS wait cycles and flags the one that hits the limit.
// Ports: clk, rst (sync, active-high), clr (restart count), en (a wait cycle),
//        expired (this wait cycle is the TIMEOUT_CYCLES-th one).
module apb_master_wdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk)
        cnt <= (rst || clr) ? '0 : en ? cnt + W'(1) : cnt;

    // Fires combinationally on the wait cycle that would bring the count to the limit,
    // so the abort lands on the same edge as that cycle's PREADY sample.
    assign expired = en && (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: APB requester turning single-beat valid/ready commands into APB transfers.
// Ports: PCLK (rising edge), PRESET (sync, active-high), bus (apb_master_bridge_if.master)
//        carrying the command port, the response port and the APB requester signals.
// Build option: define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_master_bridge_if.master bus
);
    state_t state;
    logic   expired;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef APB_MASTER_TIMEOUT_EN
    apb_master_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk    (PCLK),
        .rst    (PRESET),
        .clr    (state == SETUP),
        .en     (state == ACCESS && !bus.PREADY),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state           <= IDLE;
            bus.CMD_READY   <= 1'b0;
            bus.RSP_VALID   <= 1'b0;
            bus.RSP_RDATA   <= DATA_W'(0);
            bus.RSP_SLVERR  <= 1'b0;
            bus.RSP_TIMEOUT <= 1'b0;
            bus.PSELx       <= 1'b0;
            bus.PENABLE     <= 1'b0;
            bus.PWRITE      <= 1'b0;
            bus.PADDR       <= ADDR_W'(0);
            bus.PWDATA      <= DATA_W'(0);
        end else begin
            unique case (state)
                // CMD_READY comes out of reset low, so it is raised one cycle before the first accept.
                IDLE: if (bus.CMD_VALID && bus.CMD_READY) begin
                    bus.CMD_READY <= 1'b0;
                    bus.PSELx     <= 1'b1;
                    bus.PWRITE    <= bus.CMD_WRITE;
                    bus.PADDR     <= bus.CMD_ADDR;
                    bus.PWDATA    <= bus.CMD_WDATA;
                    state         <= SETUP;
                end else begin
                    bus.CMD_READY <= 1'b1;
                end
                SETUP: begin
                    bus.PENABLE <= 1'b1;
                    state       <= ACCESS;
                end
                // A watchdog abort is the only way to leave ACCESS with PREADY low.
                ACCESS: if (bus.PREADY || expired) begin
                    bus.PSELx       <= 1'b0;
                    bus.PENABLE     <= 1'b0;
                    bus.RSP_VALID   <= 1'b1;
                    bus.RSP_RDATA   <= (bus.PWRITE || !bus.PREADY) ? DATA_W'(0) : bus.PRDATA;
                    bus.RSP_SLVERR  <= !bus.PREADY || bus.PSLVERR;
                    bus.RSP_TIMEOUT <= !bus.PREADY;
                    state           <= RESP;
                end
                RESP: if (bus.RSP_READY) begin
                    bus.RSP_VALID <= 1'b0;
                    bus.CMD_READY <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: randomized self-checking bench for apb_master_bridge.
// Plays command source, APB completer and response sink; expectations come from the
// transaction-level rules (wait states, completion data, abort after the timeout limit).
module tb_apb_master_bridge;
    import apb_master_pkg::*;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] addrs [4] = '{ADDR_TX_FIFO, ADDR_RX_FIFO, ADDR_CONFIG, ADDR_TIMEOUT};

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK  (clk),
        .PRESET(rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {bus.CMD_READY, bus.RSP_VALID, bus.RSP_SLVERR, bus.RSP_TIMEOUT,
                            bus.PSELx, bus.PENABLE, bus.PWRITE}, 7'b0);
        chk({tag, "_paddr"}, bus.PADDR, 0);
        chk({tag, "_pwdata"}, bus.PWDATA, 0);
        chk({tag, "_rdata"}, bus.RSP_RDATA, 0);
    endtask

    // One whole transfer, called and returning at a falling edge in IDLE.
    // waits = ACCESS cycles with PREADY low before completion; rsp_delay = cycles RSP_READY stays low.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input bit err,
                        input int rsp_delay, input bit hold);
        bit          to;
        int          n_acc;
        int          guard;
        logic [31:0] exp_rdata;
        bit          exp_err;
        to        = TO_EN && waits >= TO;
        n_acc     = to ? TO : waits + 1;
        exp_rdata = (to || wr) ? 32'h0 : rdata;
        exp_err   = to ? 1'b1 : err;
        guard     = 0;
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = wr;
        bus.CMD_ADDR  = addr;
        bus.CMD_WDATA = wdata;
        while (!bus.CMD_READY && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_lat", guard, 0);
        @(negedge clk);
        chk("setup_ctl", {bus.PSELx, bus.PENABLE, bus.CMD_READY, bus.RSP_VALID}, 4'b1000);
        chk("setup_addr", bus.PADDR, addr);
        chk("setup_wdata", bus.PWDATA, wdata);
        chk("setup_write", bus.PWRITE, wr);
        bus.CMD_VALID = hold;
        if (!hold) begin
            bus.CMD_WRITE = 1'($urandom);
            bus.CMD_ADDR  = $urandom;
            bus.CMD_WDATA = $urandom;
        end
        bus.PREADY  = 1'($urandom);
        bus.PRDATA  = $urandom;
        bus.PSLVERR = 1'($urandom);
        for (int i = 0; i < n_acc; i++) begin
            @(negedge clk);
            chk("access_ctl", {bus.PSELx, bus.PENABLE, bus.RSP_VALID, bus.CMD_READY}, 4'b1100);
            chk("access_addr", bus.PADDR, addr);
            chk("access_wdata", bus.PWDATA, wdata);
            chk("access_write", bus.PWRITE, wr);
            bus.PREADY  = (i == waits);
            bus.PRDATA  = (i == waits) ? rdata : $urandom;
            bus.PSLVERR = (i == waits) ? err : 1'($urandom);
        end
        @(negedge clk);
        bus.PREADY  = 1'($urandom);
        bus.PRDATA  = $urandom;
        bus.PSLVERR = 1'($urandom);
        for (int i = 0; i <= rsp_delay; i++) begin
            chk("resp_ctl", {bus.RSP_VALID, bus.PSELx, bus.PENABLE, bus.CMD_READY}, 4'b1000);
            chk("resp_rdata", bus.RSP_RDATA, exp_rdata);
            chk("resp_slverr", bus.RSP_SLVERR, exp_err);
            chk("resp_timeout", bus.RSP_TIMEOUT, to);
            if (i == rsp_delay) bus.RSP_READY = 1'b1;
            @(negedge clk);
        end
        bus.RSP_READY = 1'b0;
        chk("idle_ctl", {bus.RSP_VALID, bus.CMD_READY, bus.PSELx, bus.PENABLE}, 4'b0100);
        chk("idle_paddr", bus.PADDR, addr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus.CMD_VALID = 1'b0;
        bus.CMD_WRITE = 1'b0;
        bus.CMD_ADDR  = '0;
        bus.CMD_WDATA = '0;
        bus.RSP_READY = 1'b0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("reset_release_ready", bus.CMD_READY, 1'b1);

        xfer(1'b1, ADDR_TX_FIFO, 32'h0000_00A5, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        xfer(1'b0, ADDR_RX_FIFO, 32'h0BAD_F00D, 3, 32'h1234_5678, 1'b0, 0, 1'b0);
        xfer(1'b1, ADDR_CONFIG, 32'h0000_3FFF, 1, 32'h5555_AAAA, 1'b1, 0, 1'b0);
        xfer(1'b0, ADDR_TIMEOUT, 32'h0, 0, 32'hCAFE_0001, 1'b0, 5, 1'b1);
        xfer(1'b1, ADDR_CONFIG, 32'h0000_0042, 0, 32'h0, 1'b0, 0, 1'b0);
`ifdef APB_MASTER_TIMEOUT_EN
        xfer(1'b0, ADDR_RX_FIFO, 32'h0, TO, 32'h7777_7777, 1'b0, 1, 1'b0);
        xfer(1'b0, ADDR_RX_FIFO, 32'h0, TO - 1, 32'h8888_8888, 1'b0, 0, 1'b0);
`endif

        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = 1'b1;
        bus.CMD_ADDR  = ADDR_CONFIG;
        bus.CMD_WDATA = 32'h1357_9BDF;
        @(negedge clk);
        bus.CMD_VALID = 1'b0;
        bus.PREADY    = 1'b0;
        @(negedge clk);
        chk("rst_mid_access", {bus.PSELx, bus.PENABLE}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_mid");
        rst = 1'b0;
        bus.PREADY = 1'b1;
        @(negedge clk);
        chk("post_rst_ctl", {bus.CMD_READY, bus.RSP_VALID, bus.PSELx, bus.PENABLE}, 4'b1000);
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_norsp", {bus.RSP_VALID, bus.PSELx}, 2'b00);
        end

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = ($urandom_range(3) == 0) ? $urandom : addrs[$urandom_range(3)];
            xfer(1'($urandom), a, $urandom, $urandom_range(TO_EN ? TO + 2 : 5), $urandom,
                 1'($urandom), $urandom_range(3), 1'($urandom));
        end
        bus.CMD_VALID = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
APB requester (initiator) that turns single-beat commands from an internal valid/ready command port into APB SETUP/ACCESS transfers. It returns the read data and error status on a valid/ready response port. It sits on the host side and drives the APB completer of the I2C subsystem: TX FIFO at 0x0, RX FIFO at 0x4, CONFIG at 0x8, TIMEOUT at 0xC. Only one transfer is outstanding at any time.

Parameters:
ADDR_W, 32, width of PADDR and CMD_ADDR.
DATA_W, 32, width of PWDATA, PRDATA, CMD_WDATA and RSP_RDATA.
TIMEOUT_CYCLES, 16, number of ACCESS cycles with PREADY low before an abort. Used only with APB_MASTER_TIMEOUT_EN; must be at least 1.

Ports:
PCLK  in  1  clock; all logic on the rising edge.
PRESET  in  1  reset; synchronous, active-high.
CMD_VALID  in  1  command request.
CMD_READY  out  1  command accepted when CMD_VALID and CMD_READY are both high.
CMD_WRITE  in  1  1 = write, 0 = read.
CMD_ADDR  in  ADDR_W  transfer address.
CMD_WDATA  in  DATA_W  write data; ignored for reads.
RSP_VALID  out  1  response available.
RSP_READY  in  1  response consumed when RSP_VALID and RSP_READY are both high.
RSP_RDATA  out  DATA_W  PRDATA captured on read completion; 0 for writes.
RSP_SLVERR  out  1  PSLVERR captured at completion, or 1 on timeout.
RSP_TIMEOUT  out  1  transfer aborted by the watchdog.
PSELx  out  1  APB select.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PADDR  out  ADDR_W  APB address.
PWDATA  out  DATA_W  APB write data.
PRDATA  in  DATA_W  APB read data.
PREADY  in  1  APB ready.
PSLVERR  in  1  APB error.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0 and the state is IDLE. Reset takes priority over everything, including mid-transfer: PSELx and PENABLE drop on the next edge and no response is generated.
- FSM states are IDLE, SETUP, ACCESS and RESP.
- IDLE:
  - CMD_READY=1, PSELx=0, PENABLE=0.
  - On CMD_VALID, latch CMD_WRITE/ADDR/WDATA into PWRITE/PADDR/PWDATA and go to SETUP.
- SETUP: PSELx=1, PENABLE=0, CMD_READY=0. Go to ACCESS unconditionally after one cycle.
- ACCESS:
  - PSELx=1, PENABLE=1. PADDR, PWDATA and PWRITE are held stable from SETUP until the transfer ends.
  - PREADY is sampled every cycle.
  - On PREADY=1: RSP_RDATA is PRDATA for a read and 0 for a write; RSP_SLVERR is PSLVERR; RSP_TIMEOUT is 0. PSELx and PENABLE drop, and the FSM goes to RESP.
- RESP:
  - RSP_VALID=1, with RSP_RDATA, RSP_SLVERR and RSP_TIMEOUT held stable.
  - On RSP_READY, go to IDLE and clear RSP_VALID.
  - A new command is not accepted until IDLE is reached.
- Latency with zero wait states:
  - Command accepted at edge N.
  - SETUP is visible after N; ACCESS after N+1.
  - PREADY is sampled at N+2; RSP_VALID is high after N+2.
  - With RSP_READY held high, CMD_READY is high again after N+3.
- PADDR, PWDATA and PWRITE keep their last values while in IDLE.
- PSLVERR and PRDATA are ignored whenever the FSM is not in ACCESS.
- PREADY high during SETUP is ignored; the ACCESS phase always occurs.
- Throughput: at most one transfer per 4 cycles.

Optional Feature:
APB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES while PREADY is still 0, the transfer is aborted: PSELx and PENABLE drop, RSP_SLVERR=1, RSP_TIMEOUT=1, RSP_RDATA=0, and the FSM goes to RESP.
  - PREADY=1 in the same cycle that the count reaches its limit counts as a normal completion.
- Undefined: ACCESS waits indefinitely, RSP_TIMEOUT is tied to 0, and TIMEOUT_CYCLES is unused.

Decomposition:
- Package apb_master_pkg contains:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - the address constants ADDR_TX_FIFO=0, ADDR_RX_FIFO=4, ADDR_CONFIG=8 and ADDR_TIMEOUT=12.
- One natural sub-module, apb_master_wdog:
  - wait counter with clear, enable and expired outputs;
  - instantiated only under the macro.

Test Plan:
- Write 0x0000_00A5 to 0x0 with PREADY tied high. Expect:
  - PSELx high for 2 cycles and PENABLE high for 1;
  - PWDATA=0xA5 stable across SETUP and ACCESS;
  - RSP_VALID after 3 edges with RSP_RDATA=0 and RSP_SLVERR=0.
- Read from 0x4 with PREADY low for 3 ACCESS cycles and PRDATA=0x1234_5678. Expect PENABLE high for 4 cycles and RSP_RDATA=0x1234_5678.
- Write 0x3FFF to 0x8 with PSLVERR=1 at completion. Expect RSP_SLVERR=1 and RSP_TIMEOUT=0.
- Hold RSP_READY low for 5 cycles with CMD_VALID held high. Expect:
  - CMD_READY=0 throughout, RSP fields stable and PSELx=0;
  - the next SETUP starts 2 edges after RSP_READY rises.
- With the macro defined and TIMEOUT_CYCLES=16, keep PREADY low. Expect an abort after 16 ACCESS cycles with RSP_SLVERR=1, RSP_TIMEOUT=1 and RSP_RDATA=0.
- Assert PRESET during ACCESS. Expect all outputs 0 after one edge, no RSP_VALID, and CMD_READY=1 once PRESET is released.
